// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus definitions: OAM DMA state encoding and the fixed
// register addresses the DMA engine snoops and targets.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HALT,
    DUMMY,
    ALIGN,
    READ,
    WRITE
  } oam_dma_state_t;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma_ctrl.sv
// NES sprite (OAM) DMA engine.
// Snoops CPU writes to TRIGGER_ADDR, halts the CPU through rdy, then copies
// 256 bytes from page {data,8'h00} to DEST_ADDR, alternating read/write cycles
// aligned to the GET/PUT parity.
// Optional build macro OAM_DMA_TRACE_EN adds the dma_cycles output reporting
// the stolen-cycle count of the most recent completed transfer.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | bus owned by CPU, watching for a trigger write
// WAIT_HALT | rdy low, CPU finishing its write run; waits for its first read
// DUMMY     | first stolen cycle, idle re-read of the frozen CPU address
// ALIGN     | extra stolen cycle so the first DMA read lands on GET
// READ      | read {page,idx}, latch bus_din
// WRITE     | write latched byte to DEST_ADDR, advance idx or finish
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = ADDR_OAMDMA,
  parameter logic [15:0] DEST_ADDR    = ADDR_OAMDATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  bus_din,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] dma_ab,
  output logic        dma_rw,
  output logic [7:0]  dma_dout
`ifdef OAM_DMA_TRACE_EN
  ,
  output logic [9:0]  dma_cycles
`endif
);

  oam_dma_state_t r_state, w_state_nxt;
  logic        r_parity;
  logic [7:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_page, w_page_nxt;
  logic        r_rdy, w_rdy_nxt;
  logic        r_active, w_active_nxt;
  logic [15:0] r_ab, w_ab_nxt;
  logic        r_rw, w_rw_nxt;
  logic [7:0]  r_dout, w_dout_nxt;
  logic        w_trigger;
  logic        w_done;

  assign rdy        = r_rdy;
  assign dma_active = r_active;
  assign dma_ab     = r_ab;
  assign dma_rw     = r_rw;
  assign dma_dout   = r_dout;

  // GET/PUT parity: free-running toggle, 0 = GET
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_parity <= 1'b0;
    else     r_parity <= ~r_parity;
  end

  // State, transfer counters and registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= 8'h00;
      r_page   <= 8'h00;
      r_rdy    <= 1'b1;
      r_active <= 1'b0;
      r_ab     <= 16'h0000;
      r_rw     <= 1'b1;
      r_dout   <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_page   <= w_page_nxt;
      r_rdy    <= w_rdy_nxt;
      r_active <= w_active_nxt;
      r_ab     <= w_ab_nxt;
      r_rw     <= w_rw_nxt;
      r_dout   <= w_dout_nxt;
    end
  end

  // Next state plus the bus values to present during the next cycle
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_page_nxt  = r_page;
    w_ab_nxt    = r_ab;
    w_rw_nxt    = r_rw;
    w_dout_nxt  = r_dout;
    w_trigger   = (r_state == IDLE) && (cpu_ab == TRIGGER_ADDR) && !cpu_rw;
    w_done      = (r_state == WRITE) && (r_idx == 8'hFF);

    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_state_nxt = WAIT_HALT;
          w_page_nxt  = cpu_dout;
          w_idx_nxt   = 8'h00;
        end
      end
      WAIT_HALT: begin
        // A read cycle means the CPU has seen rdy low and is now frozen
        if (cpu_rw) begin
          w_state_nxt = DUMMY;
          w_ab_nxt    = cpu_ab;
          w_rw_nxt    = 1'b1;
        end
      end
      DUMMY: begin
        // Next cycle is GET when the current one is PUT
        if (r_parity) begin
          w_state_nxt = READ;
          w_ab_nxt    = {r_page, r_idx};
        end else begin
          w_state_nxt = ALIGN;
        end
        w_rw_nxt = 1'b1;
      end
      ALIGN: begin
        w_state_nxt = READ;
        w_ab_nxt    = {r_page, r_idx};
        w_rw_nxt    = 1'b1;
      end
      READ: begin
        w_state_nxt = WRITE;
        w_ab_nxt    = DEST_ADDR;
        w_rw_nxt    = 1'b0;
        w_dout_nxt  = bus_din;
      end
      WRITE: begin
        w_idx_nxt = r_idx + 8'd1;
        w_rw_nxt  = 1'b1;
        if (w_done) begin
          w_state_nxt = IDLE;
          w_ab_nxt    = 16'h0000;
          w_dout_nxt  = 8'h00;
        end else begin
          w_state_nxt = READ;
          w_ab_nxt    = {r_page, r_idx + 8'd1};
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_rdy_nxt    = (w_state_nxt == IDLE);
    w_active_nxt = (w_state_nxt != IDLE) && (w_state_nxt != WAIT_HALT);
  end

`ifdef OAM_DMA_TRACE_EN
  logic [9:0] r_cyc_cnt;
  logic [9:0] r_dma_cycles;

  assign dma_cycles = r_dma_cycles;

  // Count stolen cycles from DUMMY onward; publish the total when the last WRITE ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc_cnt    <= 10'd0;
      r_dma_cycles <= 10'd0;
    end else begin
      if (r_state == WAIT_HALT && cpu_rw) r_cyc_cnt <= 10'd0;
      else if (r_active)                  r_cyc_cnt <= r_cyc_cnt + 10'd1;
      if (w_done) r_dma_cycles <= r_cyc_cnt + 10'd1;
    end
  end
`endif

endmodule
